// File: rtl/apb_slave_regfile.sv
// APB responder: bank of 32-bit R/W registers with programmable wait states and error response.
// Optional macro APB_SLV_TXN_CNT_EN adds a read-only transfer-count status word at index NUM_REGS.
module apb_slave_regfile #(
  parameter int unsigned SEL_IDX     = 0,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 10;
  localparam logic [1:0]  SEL_BIT = 2'(SEL_IDX);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic               err_q;
  logic [31:0]        wdata_q;
  logic [31:0]        regs_q [NUM_REGS];

  logic               sel;
  logic [WORD_W-1:0]  word;
  logic               in_range;
  logic               stat_hit;
  logic               setup_err;
  logic [31:0]        rd_mux;
  logic               setup_c;
  logic               done_c;
  logic               wait_c;
  logic               unused_bits;

  assign sel      = psel[SEL_BIT];
  assign word     = paddr[11:2];
  // Power-of-two bank: word < NUM_REGS is exactly "paddr[11:IDX_W+2] == 0".
  assign in_range = (word < WORD_W'(NUM_REGS));
  assign unused_bits = ^{paddr[31:12], paddr[1:0], psel};

`ifdef APB_SLV_TXN_CNT_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] rd_cnt_q;

  assign stat_hit = (word == WORD_W'(NUM_REGS));
`else
  assign stat_hit = 1'b0;
`endif

  // The status word is readable only; writing it is an error.
  assign setup_err = !in_range && !(stat_hit && !pwrite);

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      rd_mux = regs_q[word[IDX_W-1:0]];
    end
`ifdef APB_SLV_TXN_CNT_EN
    else if (stat_hit) begin
      rd_mux = {wr_cnt_q, rd_cnt_q};
    end
`endif
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    setup_c = 1'b0;
    done_c  = 1'b0;
    wait_c  = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel && !penable) begin
          state_d = ACCESS;
          setup_c = 1'b1;
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q == '0) begin
            pready  = 1'b1;
            pslverr = err_q;
            done_c  = 1'b1;
            state_d = IDLE;
          end else begin
            wait_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Setup-phase capture and wait countdown.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      prdata  <= '0;
    end else if (setup_c) begin
      cnt_q   <= CNT_W'(WAIT_CYCLES);
      idx_q   <= word[IDX_W-1:0];
      wr_q    <= pwrite;
      err_q   <= setup_err;
      wdata_q <= pwdata;
      if (!pwrite) prdata <= rd_mux;
    end else if (wait_c) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Write commits on the completion edge only.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (done_c && wr_q && !err_q) begin
      regs_q[idx_q] <= wdata_q;
    end
  end

`ifdef APB_SLV_TXN_CNT_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (done_c && !err_q) begin
      if (wr_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      else      rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: three apb_slave_regfile instances (one per psel bit, different wait counts)
// on a shared APB bus, compared against an array-based reference model.
module tb_apb_slave_regfile;

  localparam int unsigned NR = 16;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata_w  [3];
  logic        pready_w  [3];
  logic        pslverr_w [3];

  int unsigned waits [3] = '{0, 3, 2};

  logic [31:0] mem     [3][NR];
  logic [15:0] wcnt    [3];
  logic [15:0] rcnt    [3];
  logic [31:0] last_rd [3];

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  apb_slave_regfile #(.SEL_IDX(0), .NUM_REGS(NR), .WAIT_CYCLES(0)) u_s0 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));
  apb_slave_regfile #(.SEL_IDX(1), .NUM_REGS(NR), .WAIT_CYCLES(3)) u_s1 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));
  apb_slave_regfile #(.SEL_IDX(2), .NUM_REGS(NR), .WAIT_CYCLES(2)) u_s2 (
    .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  // ---------------- reference model ----------------
  function automatic logic exp_err(input logic wr, input logic [31:0] a);
    int unsigned w;
    w = int'(a[11:2]);
    if (w < NR) return 1'b0;
`ifdef APB_SLV_TXN_CNT_EN
    if (w == NR) return wr;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input int s, input logic [31:0] a);
    int unsigned w;
    w = int'(a[11:2]);
    if (w < NR) return mem[s][w];
`ifdef APB_SLV_TXN_CNT_EN
    if (w == NR) return {wcnt[s], rcnt[s]};
`endif
    return 32'h0;
  endfunction

  task automatic model_commit(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int unsigned w;
    w = int'(a[11:2]);
    if (!wr) last_rd[s] = exp_rd(s, a);
    if (exp_err(wr, a)) return;
    if (wr) begin
      if (w < NR) mem[s][w] = d;
      wcnt[s] = wcnt[s] + 16'd1;
    end else begin
      rcnt[s] = rcnt[s] + 16'd1;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < NR; i++) mem[s][i] = '0;
      wcnt[s] = '0; rcnt[s] = '0; last_rd[s] = '0;
    end
  endtask

  // ---------------- bus driver ----------------
  // Starts at posedge+1, returns at posedge+1 after the completion edge with the bus still selected.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] rdata, output logic err,
                      output int cycles, output bit ok);
    psel = 3'(1 << s); penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    ok = 1'b0; rdata = '0; err = 1'b0;
    @(posedge hclk); #1;
    penable = 1'b1;
    cycles = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      cycles++;
      @(negedge hclk);
      if (pready_w[s]) begin
        rdata = prdata_w[s]; err = pslverr_w[s]; ok = 1'b1;
      end
      @(posedge hclk); #1;
      if (!ok && scramble) begin
        paddr = $urandom; pwdata = $urandom; pwrite = ~pwrite;
      end
    end
  endtask

  // Computes expectations before the transfer, then updates the model afterwards.
  task automatic run(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input bit scramble, output logic [31:0] rdata, output logic err,
                     output int cycles, output bit ok, output logic [31:0] e_rd, output logic e_err);
    e_err = exp_err(wr, a);
    e_rd  = exp_rd(s, a);
    xfer(s, wr, a, d, scramble, rdata, err, cycles, ok);
    model_commit(s, wr, a, d);
  endtask

  task automatic bus_idle(input int n);
    psel = '0; penable = 1'b0;
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_clear();
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok;
    do_reset();
    @(negedge hclk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (pready_w[s] !== 1'b0 || pslverr_w[s] !== 1'b0 || prdata_w[s] !== 32'h0) begin
        failures++;
        $display("FAIL reset_state s%0d: pready=%b pslverr=%b prdata=%h required 0/0/0",
                 s, pready_w[s], pslverr_w[s], prdata_w[s]);
      end
    end
    @(posedge hclk); #1;
    run(0, 1'b0, 32'h0000_000C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_read_idx3: ok=%0d cycles=%0d err=%b data=%h required 1/2/0/00000000", ok, cyc, er, rd);
    end
    bus_idle(1);
  endtask

  task automatic test_status();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok;
    run(2, 1'b1, 32'h0, 32'h1111_0000, 1'b0, rd, er, cyc, ok, erd, eer);
    run(2, 1'b1, 32'h4, 32'h2222_0000, 1'b0, rd, er, cyc, ok, erd, eer);
    run(2, 1'b0, 32'h0, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    run(2, 1'b0, 32'h200, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    run(2, 1'b0, 32'h40, '0, 1'b0, rd, er, cyc, ok, erd, eer);
`ifdef APB_SLV_TXN_CNT_EN
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h0002_0001) begin
      failures++;
      $display("FAIL status_read: ok=%0d err=%b data=%h required 1/0/00020001", ok, er, rd);
    end
`else
    checks++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL status_addr_oor: ok=%0d err=%b data=%h required 1/1/00000000", ok, er, rd);
    end
`endif
    run(2, 1'b1, 32'h40, 32'hFFFF_FFFF, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || er !== 1'b1) begin
      failures++;
      $display("FAIL status_write_err: ok=%0d err=%b required 1/1", ok, er);
    end
    run(2, 1'b0, 32'h40, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || er !== eer || rd !== erd) begin
      failures++;
      $display("FAIL status_reread: err=%b data=%h required %b/%h", er, rd, eer, erd);
    end
    bus_idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok;
    run(0, 1'b1, 32'h0C, 32'hDEAD_BEEF, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 2 || er !== 1'b0) begin
      failures++;
      $display("FAIL b2b_write: ok=%0d cycles=%0d err=%b required 1/2/0", ok, cyc, er);
    end
    run(0, 1'b0, 32'h0C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL b2b_read: ok=%0d cycles=%0d err=%b data=%h required 1/2/0/deadbeef", ok, cyc, er, rd);
    end
    bus_idle(1);
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok;
    run(1, 1'b0, 32'h04, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    run(1, 1'b1, 32'h04, 32'h1234_5678, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 5 || er !== 1'b0) begin
      failures++;
      $display("FAIL wait3_write: ok=%0d cycles=%0d err=%b required 1/5/0", ok, cyc, er);
    end
    run(1, 1'b0, 32'h04, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 5 || rd !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wait3_read: ok=%0d cycles=%0d data=%h required 1/5/12345678", ok, cyc, rd);
    end
    bus_idle(1);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok;
    run(0, 1'b0, 32'h100, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || er !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL oor_read: ok=%0d err=%b data=%h required 1/1/00000000", ok, er, rd);
    end
    run(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || er !== 1'b1) begin
      failures++;
      $display("FAIL oor_write: ok=%0d err=%b required 1/1", ok, er);
    end
    run(0, 1'b0, 32'h00, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || er !== 1'b0 || rd !== 32'h0) begin
      failures++;
      $display("FAIL oor_no_alias: err=%b data=%h required 0/00000000", er, rd);
    end
    bus_idle(1);
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok; bit seen;
    run(2, 1'b1, 32'h08, 32'h1111_2222, 1'b0, rd, er, cyc, ok, erd, eer);
    bus_idle(1);
    seen = 1'b0;
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hA5A5_A5A5;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk); seen |= pready_w[2];
    @(posedge hclk); #1;
    psel = '0;
    @(negedge hclk); seen |= pready_w[2];
    @(posedge hclk); #1;
    penable = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_pready: pready seen=%b required 0", seen);
    end
    run(2, 1'b0, 32'h08, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || cyc !== 4 || rd !== 32'h1111_2222) begin
      failures++;
      $display("FAIL abort_reg_kept: ok=%0d cycles=%0d data=%h required 1/4/11112222", ok, cyc, rd);
    end
    bus_idle(1);
  endtask

  task automatic test_other_sel();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok; bit seen;
    seen = 1'b0;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFE_F00D;
    @(posedge hclk); #1;
    penable = 1'b1;
    repeat (5) begin
      @(negedge hclk); seen |= pready_w[0] | pready_w[2];
      @(posedge hclk); #1;
    end
    model_commit(1, 1'b1, 32'h0C, 32'hCAFE_F00D);
    bus_idle(1);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL other_sel_pready: unselected pready seen=%b required 0", seen);
    end
    run(0, 1'b0, 32'h0C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || rd !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL other_sel_s0: data=%h required deadbeef", rd);
    end
    run(1, 1'b0, 32'h0C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || rd !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL other_sel_s1: data=%h required cafef00d", rd);
    end
    bus_idle(1);
  endtask

  task automatic test_penable_idle();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok; bit seen;
    seen = 1'b0;
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h5555_5555;
    repeat (3) begin
      @(negedge hclk); seen |= pready_w[0];
      @(posedge hclk); #1;
    end
    bus_idle(1);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL penable_idle_pready: pready seen=%b required 0", seen);
    end
    run(0, 1'b0, 32'h10, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || rd !== 32'h0) begin
      failures++;
      $display("FAIL penable_idle_nowrite: data=%h required 00000000", rd);
    end
    bus_idle(1);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, wr; int cyc, s; bit ok;
    int unsigned w, sel;
    for (int n = 0; n < 90; n++) begin
      s   = int'($urandom_range(2, 0));
      wr  = 1'($urandom);
      d   = $urandom;
      sel = $urandom_range(7, 0);
      if (sel == 0)      w = $urandom_range(1023, 0);
      else if (sel == 1) w = NR;
      else               w = $urandom_range(NR - 1, 0);
      a = {20'($urandom), 10'(w), 2'($urandom)};
      run(s, wr, a, d, 1'b1, rd, er, cyc, ok, erd, eer);
      checks++;
      if (!ok || cyc !== 2 + int'(waits[s]) || er !== eer || (!wr && rd !== erd)) begin
        failures++;
        $display("FAIL random_xfer n=%0d s%0d wr=%b a=%h: ok=%0d cycles=%0d err=%b data=%h required 1/%0d/%b/%h",
                 n, s, wr, a, ok, cyc, er, rd, 2 + waits[s], eer, erd);
      end
      checks++;
      if (prdata_w[s] !== last_rd[s]) begin
        failures++;
        $display("FAIL random_prdata_hold n=%0d s%0d: prdata=%h required %h", n, s, prdata_w[s], last_rd[s]);
      end
      if ($urandom_range(2, 0) == 0) bus_idle(int'($urandom_range(2, 1)));
    end
    bus_idle(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int cyc; bit ok; bit bad;
    bad = 1'b0;
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h7777_7777;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(posedge hclk); #2;
    hresetn = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) bad |= pready_w[s] | pslverr_w[s] | (prdata_w[s] != 32'h0);
    psel = '0; penable = 1'b0;
    model_clear();
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: nonzero output seen=%b required 0", bad);
    end
    run(1, 1'b0, 32'h0C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || rd !== 32'h0 || cyc !== 5) begin
      failures++;
      $display("FAIL reset_mid_lost_write: ok=%0d cycles=%0d data=%h required 1/5/00000000", ok, cyc, rd);
    end
    run(0, 1'b0, 32'h0C, '0, 1'b0, rd, er, cyc, ok, erd, eer);
    checks++;
    if (!ok || rd !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_regs_cleared: data=%h required 00000000", rd);
    end
    bus_idle(1);
  endtask

  initial begin
    test_reset();
    test_status();
    test_back_to_back();
    test_wait_states();
    test_out_of_range();
    test_abort();
    test_other_sel();
    test_penable_idle();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
